// File: rtl/display_pkg.sv
// Shared constants for the BCD scan display: segment codes (active-low,
// {g,f,e,d,c,b,a}), conversion FSM states and the segment decoder.
package display_pkg;

   localparam int unsigned BCD_DIGITS = 3;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_e;

   // Decimal digit to segment pattern; codes above 9 show nothing.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial 8-bit binary to 3-digit BCD converter (shift-add-3).
// start is honoured only in IDLE; busy covers SHIFT and COMMIT.
// bcd carries the finished result while done is high (the COMMIT cycle);
// the owner latches it then so all three digits change together.
module bin2bcd_seq
   import display_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [7:0]                bin,
   output logic                      busy,
   output logic                      done,
   output logic [4*BCD_DIGITS-1:0]   bcd
);

   conv_state_e               state_q;
   logic [7:0]                bin_q;
   logic [4*BCD_DIGITS-1:0]   acc_q;
   logic [4*BCD_DIGITS-1:0]   adj_d;
   logic [2:0]                cnt_q;
   logic                      busy_q;
   logic                      done_q;

   // Add 3 to every BCD nibble that is 5 or more before the next shift.
   always_comb begin
      adj_d = acc_q;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM: capture, eight adjust-and-shift steps, one commit cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  bin_q   <= bin;
                  acc_q   <= '0;
                  cnt_q   <= 3'd7;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               {acc_q, bin_q} <= {adj_d[4*BCD_DIGITS-2:0], bin_q, 1'b0};
               cnt_q          <= cnt_q - 3'd1;
               if (cnt_q == 3'd0) begin
                  done_q  <= 1'b1;
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = acc_q;

endmodule

// File: rtl/bcd_scan_display.sv
// Display back-end: converts an 8-bit value to BCD in the background and
// time-multiplexes up to four common-anode digits, one digit per scan_tick.
// Optional macro DISP_LEADING_ZERO_BLANK_EN blanks leading-zero hundreds
// and tens digits; without it "007"-style leading zeros are shown.
module bcd_scan_display
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS           = 4,
   parameter bit          SCAN_ORDER_MSB_FIRST = 1'b0
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            value,
   input  logic                  scan_tick,
   input  logic                  blank,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  busy,
   output logic [11:0]           bcd
);

   localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

   logic [7:0]            value_q;
   logic [7:0]            last_q;
   logic [11:0]           bcd_q;
   logic [1:0]            idx_q, idx_d;
   logic                  started_q, started_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic                  conv_start;
   logic                  conv_busy;
   logic                  conv_done;
   logic [11:0]           conv_bcd;
   logic [11:0]           bcd_view;
   logic [3:0]            nib;
   logic                  is_real;
   logic                  lit;

   // A new conversion starts only when the converter is idle, so changes
   // during a conversion collapse into one restart with the latest value.
   assign conv_start = !conv_busy && (value_q != last_q);

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   (value_q),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // Forward the result in its commit cycle so a coincident scan_tick sees it.
   assign bcd_view = conv_done ? conv_bcd : bcd_q;

   // Input capture, last-converted tracking and atomic BCD commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
         last_q  <= '0;
         bcd_q   <= '0;
      end else begin
         value_q <= value;
         if (conv_start) begin
            last_q <= value_q;
         end
         if (conv_done) begin
            bcd_q <= conv_bcd;
         end
      end
   end

   // Next digit index: first tick after reset selects digit 0, later ticks step.
   always_comb begin
      idx_d     = idx_q;
      started_d = started_q;
      if (scan_tick) begin
         started_d = 1'b1;
         if (started_q) begin
            if (SCAN_ORDER_MSB_FIRST) begin
               idx_d = (idx_q == 2'd0) ? LAST_IDX : idx_q - 2'd1;
            end else begin
               idx_d = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
            end
         end
      end
   end

   // Pick the nibble for the selected digit and decide whether it lights.
   always_comb begin
      nib     = 4'd0;
      is_real = 1'b0;
      lit     = 1'b1;
      case (idx_d)
         2'd0: begin
            nib     = bcd_view[3:0];
            is_real = 1'b1;
         end
         2'd1: begin
            nib     = bcd_view[7:4];
            is_real = 1'b1;
`ifdef DISP_LEADING_ZERO_BLANK_EN
            lit     = (bcd_view[11:4] != 8'd0);
`endif
         end
         2'd2: begin
            nib     = bcd_view[11:8];
            is_real = 1'b1;
`ifdef DISP_LEADING_ZERO_BLANK_EN
            lit     = (bcd_view[11:8] != 4'd0);
`endif
         end
         default: begin
            nib     = 4'd0;
            is_real = 1'b0;
         end
      endcase
   end

   // Anode and segment patterns for the next cycle.
   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = '1;
      if (started_d && lit) begin
         seg_d = is_real ? seg_decode(nib) : SEG_BLANK;
         if (!blank) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
               if (idx_d == k[1:0]) begin
                  an_d[k] = 1'b0;
               end
            end
         end
      end
   end

   // Scan state and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         started_q <= 1'b0;
         seg_q     <= SEG_BLANK;
         an_q      <= '1;
      end else begin
         idx_q     <= idx_d;
         started_q <= started_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = conv_busy;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (NUM_DIGITS=4, LSB-first scan).
module tb_bcd_scan_display;

   localparam int ND = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    value;
   logic          scan_tick;
   logic          blank;
   logic [6:0]    seg;
   logic [ND-1:0] an;
   logic          busy;
   logic [11:0]   bcd;

   int n_assert = 0;
   int n_fail   = 0;

   // reference state
   int m_val     = 0;   // value currently committed to the display
   int m_idx     = 0;
   bit m_started = 0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   bcd_scan_display #(.NUM_DIGITS(ND), .SCAN_ORDER_MSB_FIRST(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .value     (value),
      .scan_tick (scan_tick),
      .blank     (blank),
      .seg       (seg),
      .an        (an),
      .busy      (busy),
      .bcd       (bcd)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ref_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int ref_digit(input int k, input int v);
      if (k == 0) return v % 10;
      if (k == 1) return (v / 10) % 10;
      return v / 100;
   endfunction

   function automatic bit lz_off(input int k, input int v);
`ifdef DISP_LEADING_ZERO_BLANK_EN
      return (k == 2 && v < 100) || (k == 1 && v < 10);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [ND-1:0] ref_an(input int k, input int v, input bit blk);
      logic [ND-1:0] a;
      a = '1;
      if (!blk && !lz_off(k, v)) a[k] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] ref_seg(input int k, input int v);
      if (k >= 3 || lz_off(k, v)) return 7'h7F;
      return seg_tab[ref_digit(k, v)];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one scan_tick pulse, then check the digit it selected
   task automatic do_tick();
      scan_tick = 1'b1;
      @(posedge clk); #1;
      scan_tick = 1'b0;
      m_idx     = m_started ? (m_idx + 1) % ND : 0;
      m_started = 1'b1;
      chk("an", 32'(an), 32'(ref_an(m_idx, m_val, blank)));
      chk("seg", 32'(seg), 32'(ref_seg(m_idx, m_val)));
   endtask

   task automatic set_and_wait(input int v);
      value = 8'(v);
      repeat (14) @(posedge clk);
      #1;
      m_val = v;
      chk("bcd_settle", 32'(bcd), 32'(ref_bcd(v)));
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int busy_cnt;
      int bcd_edge;
      int v;
      logic [11:0] prev;
      logic [11:0] seen [$];

      rst_n = 1'b0; value = 8'd0; scan_tick = 1'b0; blank = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_tick_an", 32'(an), 32'hF);
      chk("zero_no_conv", 32'(busy), 32'd0);
      chk("zero_bcd", 32'(bcd), 32'd0);
      for (int i = 0; i < 4; i++) do_tick();

      // 0 -> 255: latency and busy width
      value = 8'd255;
      busy_cnt = 0;
      bcd_edge = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) busy_cnt++;
         if (bcd_edge == 0 && bcd !== 12'h000) bcd_edge = e;
      end
      chk("busy_width", 32'(busy_cnt), 32'd9);
      chk("bcd_edge", 32'(bcd_edge), 32'd11);
      chk("bcd_255", 32'(bcd), 32'h255);
      m_val = 255;
      for (int i = 0; i < 4; i++) do_tick();

      // randomized values
      for (int r = 0; r < 6; r++) begin
         v = int'($urandom_range(0, 255));
         set_and_wait(v);
         for (int i = 0; i < 4; i++) do_tick();
      end

      // change while busy: only 007 then 042 get committed
      set_and_wait(200);
      value = 8'd7;
      repeat (3) @(posedge clk);
      #1;
      value = 8'd42;
      prev = bcd;
      for (int e = 0; e < 40; e++) begin
         @(posedge clk); #1;
         if (bcd !== prev) begin
            seen.push_back(bcd);
            prev = bcd;
         end
      end
      chk("commit_count", 32'(seen.size()), 32'd2);
      if (seen.size() >= 2) begin
         chk("commit_first", 32'(seen[0]), 32'h007);
         chk("commit_last", 32'(seen[1]), 32'h042);
      end
      m_val = 42;
      do_tick();

      // blank: anodes off, index keeps moving, resumes at current index
      blank = 1'b1;
      @(posedge clk); #1;
      chk("blank_an", 32'(an), 32'hF);
      do_tick();
      do_tick();
      blank = 1'b0;
      @(posedge clk); #1;
      chk("unblank_an", 32'(an), 32'(ref_an(m_idx, m_val, 1'b0)));
      chk("unblank_seg", 32'(seg), 32'(ref_seg(m_idx, m_val)));

      // reset in the middle of SHIFT
      value = 8'd99;
      repeat (4) @(posedge clk);
      #1;
      chk("busy_mid", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_bcd", 32'(bcd), 32'd0);
      chk("rst_mid_an", 32'(an), 32'hF);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_val = 0; m_idx = 0; m_started = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("bcd_099", 32'(bcd), 32'h099);
      chk("post_rst_an", 32'(an), 32'hF);
      m_val = 99;

      // scan_tick in the commit cycle uses the new value
      value = 8'd123;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_commit_bcd", 32'(bcd), 32'h099);
      m_val = 123;
      do_tick();
      chk("bcd_123", 32'(bcd), 32'h123);
      do_tick();
      do_tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
